uart_cmd_ctrl: RTL and testbench

Command-frame controller placed directly behind the UART receiver. It consumes the receiver's one-cycle byte-valid strobe and byte bus, and recognises fixed-length command frames of the form sync, opcode, address, data, checksum. Each validated frame is presented as one command on a valid/ready handshake to the sensor register/config logic. It also detects checksum failures, inter-byte timeouts and overruns.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_cmd_gap_timer.sv | 32 +++
 rtl/uart_cmd_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
// The checksum byte and CHK state are present only when UART_CMD_CHKSUM_EN is defined.
package uart_cmd_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned TMR_W           = 16;
  localparam logic [7:0]  DEF_SYNC_BYTE   = 8'hAA;
  localparam int unsigned FRAME_LEN_CHK   = 5;
  localparam int unsigned FRAME_LEN_NOCHK = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_OP    = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4,
    ST_ISSUE = 3'd5
  } state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] data;
  } uart_cmd_t;

endpackage

// File: rtl/uart_cmd_gap_timer.sv
// Inter-byte gap counter: counts enabled cycles without a byte and flags the
// TIMEOUT_CLKS-th such cycle since the last clear.
module uart_cmd_gap_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CLKS - 1);

  logic [TMR_W-1:0] count_q;

  // Held at zero outside the frame body so entry to OP always starts fresh.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      count_q <= '0;
    end else if (clr || !en) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TMR_W'(1);
    end
  end

  assign expire_c = en && !clr && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames UART bytes (sync, op, addr, data[, checksum]) into valid/ready commands.
// Define UART_CMD_CHKSUM_EN to add the XOR checksum byte and o_Err_Chk.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Cmd_Valid,
  input  logic       i_Cmd_Ready,
  output logic [7:0] o_Cmd_Op,
  output logic [7:0] o_Cmd_Addr,
  output logic [7:0] o_Cmd_Data,
  output logic       o_Err_Chk,
  output logic       o_Err_Tmo,
  output logic       o_Err_Ovf,
  output logic       o_Busy
);

  state_e    state;
  uart_cmd_t cmd_q;
  logic      gap_en_c;
  logic      gap_tmo_c;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] xor_q;
  logic       err_chk_q;
`endif

  assign gap_en_c = (state == ST_OP) || (state == ST_ADDR) ||
                    (state == ST_DATA) || (state == ST_CHK);

  uart_cmd_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .clr      (i_Rx_DV),
    .en       (gap_en_c),
    .expire_c (gap_tmo_c)
  );

  // Frame FSM; expiry only fires in cycles without a byte, so a late byte still wins.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Err_Tmo   <= 1'b0;
      o_Err_Ovf   <= 1'b0;
      o_Busy      <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
      xor_q       <= '0;
      err_chk_q   <= 1'b0;
`endif
    end else begin
      o_Err_Tmo <= 1'b0;
      o_Err_Ovf <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
      err_chk_q <= 1'b0;
`endif
      if (gap_tmo_c) begin
        state     <= ST_IDLE;
        o_Busy    <= 1'b0;
        o_Err_Tmo <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
              state  <= ST_OP;
              o_Busy <= 1'b1;
`ifdef UART_CMD_CHKSUM_EN
              xor_q  <= '0;
`endif
            end
          end
          ST_OP: begin
            if (i_Rx_DV) begin
              cmd_q.op <= i_Rx_Byte;
`ifdef UART_CMD_CHKSUM_EN
              xor_q    <= xor_q ^ i_Rx_Byte;
`endif
              state    <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (i_Rx_DV) begin
              cmd_q.addr <= i_Rx_Byte;
`ifdef UART_CMD_CHKSUM_EN
              xor_q      <= xor_q ^ i_Rx_Byte;
`endif
              state      <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (i_Rx_DV) begin
              cmd_q.data <= i_Rx_Byte;
`ifdef UART_CMD_CHKSUM_EN
              xor_q      <= xor_q ^ i_Rx_Byte;
              state      <= ST_CHK;
`else
              state       <= ST_ISSUE;
              o_Cmd_Valid <= 1'b1;
`endif
            end
          end
`ifdef UART_CMD_CHKSUM_EN
          ST_CHK: begin
            if (i_Rx_DV) begin
              if (i_Rx_Byte == xor_q) begin
                state       <= ST_ISSUE;
                o_Cmd_Valid <= 1'b1;
              end else begin
                state     <= ST_IDLE;
                o_Busy    <= 1'b0;
                err_chk_q <= 1'b1;
              end
            end
          end
`endif
          ST_ISSUE: begin
            if (i_Rx_DV) begin
              o_Err_Ovf <= 1'b1;
            end
            if (i_Cmd_Ready) begin
              state       <= ST_IDLE;
              o_Cmd_Valid <= 1'b0;
              o_Busy      <= 1'b0;
            end
          end
          default: begin
            state       <= ST_IDLE;
            o_Cmd_Valid <= 1'b0;
            o_Busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_Cmd_Op   = cmd_q.op;
  assign o_Cmd_Addr = cmd_q.addr;
  assign o_Cmd_Data = cmd_q.data;
`ifdef UART_CMD_CHKSUM_EN
  assign o_Err_Chk  = err_chk_q;
`else
  assign o_Err_Chk  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl; frame length follows UART_CMD_CHKSUM_EN.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int unsigned TMO = 100;
`ifdef UART_CMD_CHKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b1;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       i_Cmd_Ready = 1'b0;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data;
  logic       o_Err_Chk, o_Err_Tmo, o_Err_Ovf, o_Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_chk  = 0;
  int cnt_tmo  = 0;
  int cnt_ovf  = 0;
  uart_cmd_t sb[$];

  uart_cmd_ctrl #(
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Cmd_Valid (o_Cmd_Valid),
    .i_Cmd_Ready (i_Cmd_Ready),
    .o_Cmd_Op    (o_Cmd_Op),
    .o_Cmd_Addr  (o_Cmd_Addr),
    .o_Cmd_Data  (o_Cmd_Data),
    .o_Err_Chk   (o_Err_Chk),
    .o_Err_Tmo   (o_Err_Tmo),
    .o_Err_Ovf   (o_Err_Ovf),
    .o_Busy      (o_Busy)
  );

  always #5 i_CLK = ~i_CLK;

  // Total error pulses seen, used to prove no spurious errors between scenarios.
  always @(posedge i_CLK) begin
    if (o_Err_Chk === 1'b1) cnt_chk++;
    if (o_Err_Tmo === 1'b1) cnt_tmo++;
    if (o_Err_Ovf === 1'b1) cnt_ovf++;
  end

  // Called at a negedge; the byte is sampled at the following posedge.
  task automatic drive_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_CLK);
    i_Rx_DV   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] fr [FRAME_LEN];
    fr[0] = 8'hAA;
    fr[1] = op;
    fr[2] = addr;
    fr[3] = data;
`ifdef UART_CMD_CHKSUM_EN
    fr[4] = op ^ addr ^ data;
`endif
    sb.push_back({op, addr, data});
    for (int unsigned i = 0; i < FRAME_LEN; i++) drive_byte(fr[i]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_CLK);
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, o_Err_Chk, o_Err_Tmo, o_Err_Ovf, o_Busy} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b op=%h a=%h d=%h chk=%b tmo=%b ovf=%b busy=%b, want all 0",
               o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, o_Err_Chk, o_Err_Tmo, o_Err_Ovf, o_Busy);
    end
    i_RST = 1'b0;
    @(negedge i_CLK);
  endtask

  task automatic test_good_frame();
    uart_cmd_t exp;
    int e0 = cnt_chk + cnt_tmo + cnt_ovf;
    i_Cmd_Ready = 1'b1;
    send_frame(8'h01, 8'h10, 8'h5A);
    exp = sb.pop_front();
    n_checks++;
    if (o_Cmd_Valid !== 1'b1) begin
      n_fail++; $display("FAIL good_valid: got %b want 1", o_Cmd_Valid);
    end
    n_checks++;
    if ({o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== exp) begin
      n_fail++; $display("FAIL good_cmd: got %h%h%h want %h", o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    @(negedge i_CLK);
    n_checks++;
    if ({o_Cmd_Valid, o_Busy} !== 2'b00) begin
      n_fail++; $display("FAIL good_one_cycle: got valid/busy %b%b want 00", o_Cmd_Valid, o_Busy);
    end
    repeat (2) @(negedge i_CLK);
    n_checks++;
    if (cnt_chk + cnt_tmo + cnt_ovf !== e0) begin
      n_fail++; $display("FAIL good_no_err: got %0d error pulses want 0", cnt_chk + cnt_tmo + cnt_ovf - e0);
    end
  endtask

`ifdef UART_CMD_CHKSUM_EN
  task automatic test_bad_chk();
    i_Cmd_Ready = 1'b1;
    drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h10); drive_byte(8'h5A); drive_byte(8'h00);
    n_checks++;
    if ({o_Err_Chk, o_Cmd_Valid, o_Busy} !== 3'b100) begin
      n_fail++; $display("FAIL badchk_pulse: got chk/valid/busy %b%b%b want 100", o_Err_Chk, o_Cmd_Valid, o_Busy);
    end
    @(negedge i_CLK);
    n_checks++;
    if ({o_Err_Chk, o_Cmd_Valid} !== 2'b00) begin
      n_fail++; $display("FAIL badchk_width: got chk/valid %b%b want 00", o_Err_Chk, o_Cmd_Valid);
    end
  endtask
`endif

  task automatic test_ignore();
    uart_cmd_t exp;
    i_Cmd_Ready = 1'b1;
    drive_byte(8'h55);
    drive_byte(8'h33);
    n_checks++;
    if (o_Busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_busy: got %b want 0", o_Busy);
    end
    send_frame(8'h02, 8'h20, 8'hFF);
    exp = sb.pop_front();
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL ignore_cmd: got v=%b %h%h%h want v=1 %h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    @(negedge i_CLK);
  endtask

  task automatic test_timeout();
    uart_cmd_t exp;
    int t0 = cnt_tmo;
    i_Cmd_Ready = 1'b1;
    drive_byte(8'hAA);
    drive_byte(8'h01);
    repeat (TMO - 1) @(negedge i_CLK);
    n_checks++;
    if ({o_Err_Tmo, o_Busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_early: got tmo/busy %b%b want 01", o_Err_Tmo, o_Busy);
    end
    @(negedge i_CLK);
    n_checks++;
    if ({o_Err_Tmo, o_Busy} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_pulse: got tmo/busy %b%b want 10", o_Err_Tmo, o_Busy);
    end
    @(negedge i_CLK);
    n_checks++;
    if (o_Err_Tmo !== 1'b0) begin
      n_fail++; $display("FAIL tmo_width: got %b want 0", o_Err_Tmo);
    end
    // Byte lands exactly in the expiry cycle and must be consumed.
    sb.push_back({8'h03, 8'h04, 8'h05});
    drive_byte(8'hAA);
    drive_byte(8'h03);
    repeat (TMO - 1) @(negedge i_CLK);
    drive_byte(8'h04);
    n_checks++;
    if ({o_Err_Tmo, o_Busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_dv_wins: got tmo/busy %b%b want 01", o_Err_Tmo, o_Busy);
    end
    drive_byte(8'h05);
`ifdef UART_CMD_CHKSUM_EN
    drive_byte(8'h02);
`endif
    exp = sb.pop_front();
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL tmo_late_cmd: got v=%b %h%h%h want v=1 %h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    repeat (2) @(negedge i_CLK);
    n_checks++;
    if (cnt_tmo - t0 !== 1) begin
      n_fail++; $display("FAIL tmo_count: got %0d timeouts want 1", cnt_tmo - t0);
    end
  endtask

  task automatic test_overflow();
    uart_cmd_t exp;
    int o0 = cnt_ovf;
    i_Cmd_Ready = 1'b0;
    send_frame(8'h11, 8'h22, 8'h33);
    exp = sb.pop_front();
    repeat (3) @(negedge i_CLK);
    drive_byte(8'h77);
    n_checks++;
    if ({o_Err_Ovf, o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== {2'b11, exp}) begin
      n_fail++; $display("FAIL ovf_pulse: got ovf=%b v=%b %h%h%h want 1 1 %h", o_Err_Ovf, o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    @(negedge i_CLK);
    n_checks++;
    if (o_Err_Ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_width: got %b want 0", o_Err_Ovf);
    end
    repeat (50) @(negedge i_CLK);
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL ovf_hold: got v=%b %h%h%h want v=1 %h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    // A sync byte in the transfer cycle is dropped, not treated as a new frame.
    i_Cmd_Ready = 1'b1;
    drive_byte(8'hAA);
    n_checks++;
    if ({o_Cmd_Valid, o_Err_Ovf, o_Busy} !== 3'b010) begin
      n_fail++; $display("FAIL ovf_transfer: got valid/ovf/busy %b%b%b want 010", o_Cmd_Valid, o_Err_Ovf, o_Busy);
    end
    repeat (2) @(negedge i_CLK);
    n_checks++;
    if ({o_Busy, 32'(cnt_ovf - o0)} !== {1'b0, 32'd2}) begin
      n_fail++; $display("FAIL ovf_count: got busy=%b ovf=%0d want busy=0 ovf=2", o_Busy, cnt_ovf - o0);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    i_Cmd_Ready = 1'b1;
    drive_byte(8'hAA);
    drive_byte(8'h01);
    e0 = cnt_chk + cnt_tmo + cnt_ovf;
    i_RST = 1'b1;
    #1;
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, o_Err_Chk, o_Err_Tmo, o_Err_Ovf, o_Busy} !== 29'd0) begin
      n_fail++; $display("FAIL rst_mid_frame: got op=%h busy=%b, want all outputs 0", o_Cmd_Op, o_Busy);
    end
    @(negedge i_CLK);
    i_RST = 1'b0;
    i_Cmd_Ready = 1'b0;
    @(negedge i_CLK);
    send_frame(8'h44, 8'h55, 8'h66);
    void'(sb.pop_front());
    i_RST = 1'b1;
    #1;
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Busy} !== 10'd0) begin
      n_fail++; $display("FAIL rst_mid_issue: got v=%b op=%h busy=%b want 0", o_Cmd_Valid, o_Cmd_Op, o_Busy);
    end
    @(negedge i_CLK);
    i_RST = 1'b0;
    repeat (3) @(negedge i_CLK);
    n_checks++;
    if ({o_Cmd_Valid, 32'(cnt_chk + cnt_tmo + cnt_ovf - e0)} !== 33'd0) begin
      n_fail++; $display("FAIL rst_no_err: got valid=%b errors=%0d want 0 0", o_Cmd_Valid, cnt_chk + cnt_tmo + cnt_ovf - e0);
    end
  endtask

  task automatic test_back_to_back();
    uart_cmd_t exp;
    i_Cmd_Ready = 1'b1;
    send_frame(8'hAA, 8'h11, 8'h22);
    exp = sb.pop_front();
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL b2b_first: got v=%b %h%h%h want v=1 %h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    @(negedge i_CLK);
    send_frame(8'h5A, 8'hA5, 8'h3C);
    exp = sb.pop_front();
    n_checks++;
    if ({o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL b2b_second: got v=%b %h%h%h want v=1 %h", o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data, exp);
    end
    @(negedge i_CLK);
    n_checks++;
    if (o_Cmd_Valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drop: got %b want 0", o_Cmd_Valid);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
`ifdef UART_CMD_CHKSUM_EN
    test_bad_chk();
`endif
    test_ignore();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
`ifndef UART_CMD_CHKSUM_EN
    n_checks++;
    if (cnt_chk !== 0) begin
      n_fail++; $display("FAIL nochk_err: got %0d checksum pulses want 0", cnt_chk);
    end
`endif
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL sb_empty: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
